spi_cop0: RTL and testbench
===========================

// Module: spi_cop0
// PURPOSE
//  SPI master coprocessor that consumes spi_ctrl from the decode stage (MTC0 -> `MT, MFC0 -> `MF).
//  MT writes the register-file read data to a coprocessor register selected by the instruction rd field.
//  MF returns coprocessor register contents on rdata, which feeds the REG_SRC_SPI write-back mux.
//  Drives one mode-0 SPI bus (CPOL=0, CPHA=0), MSB first. Asserts stall while an access cannot complete.
// PARAMETERS
//  XFER_BITS  8  bits per transfer, valid range 1..32
//  DIV_W      8  width of the clock divider register
//  DIV_RST    4  reset value of the divider; SCLK half-period = DIV+1 clk cycles
// PORTS
//  clk       in   1             single system clock; all state changes on the rising edge
//  rst_n     in   1             asynchronous assert, active-low reset
//  spi_ctrl  in   `W_SPI_CTRL   `SPI_NOP / `MT / `MF from decode
//  cp0_sel   in   `W_REG        coprocessor register select (instruction rd field)
//  wdata     in   32            MT data (register-file read port 1)
//  rdata     out  32            MF data to write-back; combinational from cp0_sel
//  stall     out  1             hold the PC and suppress reg_wen this cycle; combinational
//  sclk      out  1             SPI clock
//  mosi      out  1             SPI data out
//  miso      in   1             SPI data in; sampled on SCLK rising edge
//  cs_n      out  1             chip select, software controlled
// BEHAVIOUR
//  Register map:
//   sel 0 DATA: MT starts a transfer of wdata[XFER_BITS-1:0]. MF returns zero-extended rx_data and clears rx_valid.
//   sel 1 CTRL/STAT: MT sets cs_n = ~wdata[0]. MF returns {30'b0, rx_valid, busy}.
//   sel 2 DIV: MT loads wdata[DIV_W-1:0]. MF returns the zero-extended DIV value.
//   Other sels: MF returns 0. MT is ignored and never stalls.
//  Reset values: sclk=0, mosi=0, cs_n=1, DIV=DIV_RST, rx_data=0, rx_valid=0, state=IDLE, stall=0.
//  Reset in the middle of a transfer aborts it at once. No partial rx_data is kept.
//  FSM states IDLE -> SHIFT -> DONE -> IDLE. busy = (state != IDLE).
//   IDLE: MT DATA loads the shift register, sets mosi = bit[XFER_BITS-1], clears the tick counter, goes to SHIFT.
//   SHIFT: a tick every DIV+1 clk cycles toggles sclk.
//     On a rising edge: shift miso into the LSB.
//     On a falling edge: drive the next MSB onto mosi.
//     After the XFER_BITS-th falling edge, sclk=0; go to DONE.
//   DONE: one cycle. rx_data <= shift register, rx_valid <= 1, then go to IDLE.
//  Latency: MT DATA to busy low is 2*XFER_BITS*(DIV+1)+1 cycles. With DIV=0 and 8 bits this is 17 cycles.
//  stall = busy & ((spi_ctrl==`MT & sel in {0,1,2}) | (spi_ctrl==`MF & sel==0)).
//   A stalled access has no side effects: no load, no clear of rx_valid.
//   MF STAT never stalls, so software can poll it.
//  Simultaneous events:
//   DONE cycle plus MF DATA: the access stalls. It completes the next cycle with the new byte.
//   A fresh transfer overwrites rx_data even if rx_valid is still 1. No overrun flag.
//  DIV is fixed while busy: a write to it stalls. cs_n is never changed by the FSM.
// STRUCTURE
//  Shared defines in lib/opcodes.v: CP0_SEL_DATA=0, CP0_SEL_CTRL=1, CP0_SEL_DIV=2, STAT_BUSY=0, STAT_RXV=1.
//  `MT / `MF / `SPI_NOP are already defined there.
//  Sub-module spi_tick_gen: DIV_W down-counter with a clear input. Emits a 1-cycle tick when the count reaches 0.
//  The FSM, shift register and register map stay in spi_cop0.
// TESTING
//  1. Release reset -> cs_n=1, sclk=0, stall=0. MF sel1 -> 0x0. MF sel2 -> 0x4.
//  2. MT sel2=0, MT sel1=1, MT sel0=0xA5 with miso looped from mosi:
//     -> mosi 1,0,1,0,0,1,0,1 at rising edges, busy for 17 cycles.
//     -> MF sel1 -> 0x2. MF sel0 -> 0xA5, then MF sel1 -> 0x0.
//  3. MT sel0=0x3C while busy -> stall=1 until IDLE, shift register unchanged. Then a 0x3C transfer runs.
//  4. While busy: MF sel0 -> stall=1. MF sel1 -> 0x1 with stall=0. MT sel5 -> stall=0, no effect.
//  5. Assert rst_n after 3 SCLK rising edges -> sclk=0, cs_n=1, rx_valid=0 immediately.
//     The next 0x81 transfer is correct.
//  6. DIV=3, miso=1 -> sclk half-period 4 cycles, rx_data 0xFF after 65 cycles. MF sel7 -> 0x0.

Source files
------------

// File: rtl/spi_cop0_pkg.sv
// Shared encodings for the SPI coprocessor: decode-stage access codes,
// coprocessor register selects and the status word layout.
package spi_cop0_pkg;

  localparam int unsigned W_SPI_CTRL = 2;
  localparam int unsigned W_REG      = 5;
  // Wide enough for a bit index up to 31 (XFER_BITS <= 32).
  localparam int unsigned CNT_W      = 6;

  typedef logic [W_SPI_CTRL-1:0] spi_ctrl_t;
  typedef logic [W_REG-1:0]      cp0_sel_t;

  localparam spi_ctrl_t SPI_NOP = 2'd0;
  localparam spi_ctrl_t MT      = 2'd1;
  localparam spi_ctrl_t MF      = 2'd2;

  localparam cp0_sel_t CP0_SEL_DATA = 5'd0;
  localparam cp0_sel_t CP0_SEL_CTRL = 5'd1;
  localparam cp0_sel_t CP0_SEL_DIV  = 5'd2;

  // Status word returned by MF CTRL/STAT: bit 0 busy, bit 1 rx_valid.
  typedef struct packed {
    logic [29:0] rsvd;
    logic        rx_valid;
    logic        busy;
  } stat_t;

endpackage

// File: rtl/spi_tick_gen.sv
// SCLK pacing counter: reloads from div on clr or on reaching zero and
// emits a one-cycle tick_c every div+1 enabled cycles.
// Ports: clk, rst_n, clr (reload now), en (count), div (reload value),
//        tick_c (combinational tick).
module spi_tick_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_c = en & ~clr & (cnt_q == '0);

  // Down-counter with reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= div;
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? div : cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_cop0.sv
// SPI mode-0 master coprocessor. MT writes DATA/CTRL/DIV, MF reads them back.
// Ports: clk, rst_n, spi_ctrl (NOP/MT/MF), cp0_sel (register select),
//        wdata (MT data), rdata (MF data, combinational), stall
//        (combinational), sclk/mosi/cs_n (SPI outputs), miso (SPI input).
module spi_cop0
  import spi_cop0_pkg::*;
#(
  parameter int unsigned XFER_BITS = 8,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_RST   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_SPI_CTRL-1:0] spi_ctrl,
  input  logic [W_REG-1:0]      cp0_sel,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  stall,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state_q,    state_d;
  logic [XFER_BITS-1:0] shift_q,    shift_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [XFER_BITS-1:0] rx_data_q,  rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DIV_W-1:0]     div_q,      div_d;
  logic                 sclk_q,     sclk_d;
  logic                 mosi_q,     mosi_d;
  logic                 cs_n_q,     cs_n_d;

  logic busy_c;
  logic acc_mt_c;
  logic acc_mf_data_c;
  logic start_c;
  logic tick_c;
  logic unused_wdata;

  assign unused_wdata = ^wdata;

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;

  // Access classification and stall: mapped MTs and MF DATA wait for IDLE.
  assign busy_c        = (state_q != ST_IDLE);
  assign acc_mt_c      = (spi_ctrl == MT) &&
                         ((cp0_sel == CP0_SEL_DATA) || (cp0_sel == CP0_SEL_CTRL) ||
                          (cp0_sel == CP0_SEL_DIV));
  assign acc_mf_data_c = (spi_ctrl == MF) && (cp0_sel == CP0_SEL_DATA);
  assign stall         = busy_c & (acc_mt_c | acc_mf_data_c);

  spi_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_c),
    .en     (state_q == ST_SHIFT),
    .div    (div_q),
    .tick_c (tick_c)
  );

  // Read mux, independent of spi_ctrl so write-back sees it early.
  always_comb begin
    stat_t stat;
    stat          = '0;
    stat.rx_valid = rx_valid_q;
    stat.busy     = busy_c;
    rdata         = '0;
    case (cp0_sel)
      CP0_SEL_DATA: rdata = 32'(rx_data_q);
      CP0_SEL_CTRL: rdata = stat;
      CP0_SEL_DIV:  rdata = 32'(div_q);
      default:      rdata = '0;
    endcase
  end

  // Next-state, shifter and register-map side effects.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    start_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((spi_ctrl == MT) && (cp0_sel == CP0_SEL_DATA)) begin
          shift_d   = wdata[XFER_BITS-1:0];
          mosi_d    = wdata[XFER_BITS-1];
          bit_cnt_d = '0;
          start_c   = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          if (!sclk_q) begin
            // Rising edge: sample miso into the LSB.
            sclk_d  = 1'b1;
            shift_d = XFER_BITS'({shift_q, miso});
          end else begin
            // Falling edge: present the next bit, or finish after the last one.
            sclk_d = 1'b0;
            if (bit_cnt_q == CNT_W'(XFER_BITS - 1)) begin
              state_d = ST_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              mosi_d    = shift_q[XFER_BITS-1];
            end
          end
        end
      end
      ST_DONE: begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // CTRL, DIV and the rx_valid clear only take effect when not stalled.
    if (!busy_c) begin
      if ((spi_ctrl == MT) && (cp0_sel == CP0_SEL_CTRL)) cs_n_d = ~wdata[0];
      if ((spi_ctrl == MT) && (cp0_sel == CP0_SEL_DIV))  div_d  = wdata[DIV_W-1:0];
      if (acc_mf_data_c)                                 rx_valid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      div_q      <= DIV_W'(DIV_RST);
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_spi_cop0.sv
// Directed bench for spi_cop0 with scoreboard queues of expected rx/tx bytes.
module tb_spi_cop0;
  import spi_cop0_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  spi_ctrl_t   spi_ctrl = SPI_NOP;
  cp0_sel_t    cp0_sel  = '0;
  logic [31:0] wdata    = '0;
  logic [31:0] rdata;
  logic        stall, sclk, mosi, miso, cs_n;
  logic        loop_en  = 1'b1;
  logic        miso_drv = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] rx_q[$];
  logic [7:0]  tx_q[$];

  logic [31:0] mosi_cap = '0;
  int          rise_cnt = 0;
  int          hi_run   = 0;
  int          hi_last  = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_drv;

  spi_cop0 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_ctrl (spi_ctrl),
    .cp0_sel  (cp0_sel),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  // Bus monitor: mosi as seen at each SCLK rising edge.
  always @(posedge sclk) begin
    mosi_cap <= {mosi_cap[30:0], mosi};
    rise_cnt <= rise_cnt + 1;
  end

  // Length of the most recent SCLK high phase in clk cycles.
  always @(negedge clk) begin
    if (sclk) hi_run <= hi_run + 1;
    else if (hi_run != 0) begin
      hi_last <= hi_run;
      hi_run  <= 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_rx(output logic [31:0] v);
    if (rx_q.size() == 0) v = 'x;
    else v = rx_q.pop_front();
  endtask

  task automatic mt(input cp0_sel_t sel, input logic [31:0] d, input logic exp_stall,
                    input string tag);
    spi_ctrl = MT; cp0_sel = sel; wdata = d;
    #1;
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    step();
    spi_ctrl = SPI_NOP;
  endtask

  task automatic mf(input cp0_sel_t sel, input logic [31:0] exp, input string tag);
    spi_ctrl = MF; cp0_sel = sel;
    #1;
    chk(tag, rdata, exp);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    step();
    spi_ctrl = SPI_NOP;
  endtask

  task automatic peek(input cp0_sel_t sel, input logic [31:0] exp, input string tag);
    spi_ctrl = SPI_NOP; cp0_sel = sel;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic start(input logic [31:0] d, input logic [31:0] exp_rx);
    rx_q.push_back(exp_rx);
    tx_q.push_back(d[7:0]);
    mt(CP0_SEL_DATA, d, 1'b0, "start");
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] e;
    pop_rx(e);
    mf(CP0_SEL_DATA, e, tag);
  endtask

  task automatic check_tx(input string tag);
    logic [7:0] e;
    if (tx_q.size() == 0) e = 'x;
    else e = tx_q.pop_front();
    chk(tag, 32'(mosi_cap[7:0]), 32'(e));
  endtask

  // Polls STAT (never stalls) until busy drops; returns cycles spent busy.
  task automatic wait_idle(output int n);
    logic saw_stall;
    saw_stall = 1'b0;
    n = 0;
    spi_ctrl = MF; cp0_sel = CP0_SEL_CTRL;
    while (n < 2000) begin
      #1;
      saw_stall |= stall;
      if (!rdata[0]) break;
      @(posedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'(n), 32'd0);
    chk("poll_stall", 32'(saw_stall), 32'd0);
    spi_ctrl = SPI_NOP;
    step();
  endtask

  initial begin
    int n;
    int base;
    logic [31:0] e;

    // Reset state
    step(); step(); step();
    chk("rst_sclk",  32'(sclk),  32'd0);
    chk("rst_cs_n",  32'(cs_n),  32'd1);
    chk("rst_mosi",  32'(mosi),  32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    step();
    mf(CP0_SEL_CTRL, 32'h0, "rst_stat");
    mf(CP0_SEL_DIV,  32'h4, "rst_div");
    mf(CP0_SEL_DATA, 32'h0, "rst_data");

    // Loopback transfer of 0xA5 at DIV=0
    mt(CP0_SEL_DIV,  32'h0, 1'b0, "div0");
    mt(CP0_SEL_CTRL, 32'h1, 1'b0, "cs_on");
    chk("cs_low", 32'(cs_n), 32'd0);
    start(32'hA5, 32'hA5);
    wait_idle(n);
    chk("lat_a5", 32'(n), 32'd17);
    chk("half_div0", 32'(hi_last), 32'd1);
    mf(CP0_SEL_CTRL, 32'h2, "stat_rxv");
    check_rx("rx_a5");
    mf(CP0_SEL_CTRL, 32'h0, "stat_clr");
    check_tx("tx_a5");

    // MT DATA while busy holds until IDLE, then the held access runs
    start(32'h3C, 32'h3C);
    rx_q.push_back(32'h77);
    tx_q.push_back(8'h77);
    spi_ctrl = MT; cp0_sel = CP0_SEL_DATA; wdata = 32'h77;
    n = 0;
    while (n < 200) begin
      #1;
      if (!stall) break;
      @(posedge clk);
      n++;
    end
    chk("hold_stall", 32'(n), 32'd17);
    check_tx("tx_3c");
    step();
    spi_ctrl = SPI_NOP;

    // Accesses during the 0x77 transfer
    pop_rx(e);
    peek(CP0_SEL_DATA, e, "rx_3c_kept");
    mf(CP0_SEL_CTRL, 32'h3, "stat_busy");
    mt(5'd5, 32'hFFFF_FFFF, 1'b0, "mt_sel5");
    mt(CP0_SEL_DIV,  32'h9, 1'b1, "div_busy");
    mt(CP0_SEL_CTRL, 32'h0, 1'b1, "ctrl_busy");
    // MF DATA stalls through DONE and returns the fresh byte
    pop_rx(e);
    spi_ctrl = MF; cp0_sel = CP0_SEL_DATA;
    n = 0;
    while (n < 200) begin
      #1;
      if (!stall) break;
      @(posedge clk);
      n++;
    end
    chk("mf_hold_gt0", 32'(n > 0), 32'd1);
    chk("rx_77", rdata, e);
    step();
    spi_ctrl = SPI_NOP;
    mf(CP0_SEL_CTRL, 32'h0, "stat_after_77");
    mf(CP0_SEL_DIV,  32'h0, "div_kept");
    chk("cs_kept", 32'(cs_n), 32'd0);
    check_tx("tx_77");

    // DIV=3 with miso held high
    mt(CP0_SEL_DIV, 32'h3, 1'b0, "div3");
    loop_en = 1'b0; miso_drv = 1'b1;
    start(32'h00, 32'hFF);
    wait_idle(n);
    chk("lat_div3", 32'(n), 32'd65);
    chk("half_div3", 32'(hi_last), 32'd4);
    mf(CP0_SEL_CTRL, 32'h2, "stat_ff");
    pop_rx(e);
    peek(CP0_SEL_DATA, e, "rx_ff");
    mf(5'd7, 32'h0, "mf_sel7");
    mt(5'd7, 32'h5, 1'b0, "mt_sel7");
    mf(CP0_SEL_DIV, 32'h3, "div3_rb");
    check_tx("tx_00");

    // Reset after the third SCLK rising edge of a transfer
    loop_en = 1'b1;
    mt(CP0_SEL_DIV, 32'h0, 1'b0, "div0b");
    base = rise_cnt;
    mt(CP0_SEL_DATA, 32'h81, 1'b0, "start_abort");
    n = 0;
    while ((rise_cnt - base) < 3 && n < 200) begin
      step();
      n++;
    end
    chk("abort_rises", 32'(rise_cnt - base), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("ab_sclk", 32'(sclk), 32'd0);
    chk("ab_cs_n", 32'(cs_n), 32'd1);
    chk("ab_mosi", 32'(mosi), 32'd0);
    peek(CP0_SEL_CTRL, 32'h0, "ab_stat");
    peek(CP0_SEL_DATA, 32'h0, "ab_data");
    peek(CP0_SEL_DIV,  32'h4, "ab_div");
    step();
    rst_n = 1'b1;
    step();

    // Transfer after reset runs at the reset divider (DIV=4)
    mt(CP0_SEL_CTRL, 32'h1, 1'b0, "cs_on2");
    start(32'h81, 32'h81);
    wait_idle(n);
    chk("lat_div4", 32'(n), 32'd81);
    check_rx("rx_81");
    check_tx("tx_81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
